fpga_rst_seq: RTL and testbench
===============================

FPGA_RST_SEQ -- requirements
Module: fpga_rst_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- LOCK_CYC, 16: consecutive synchronised pll_locked-high cycles required.
- HOLD_CYC, 64: minimum reset hold cycles.
- GAP_CYC, 8: cycles between debug release and system release.
- CNT_W, 8: counter width; each parameter SHALL be at least 1 and at most 2^CNT_W.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- fpga_clk_in, in, 1: the single clock.
- fpga_rst_in, in, 1: reset, asynchronous, active-low.
- pll_locked, in, 1: clock-generator lock, asynchronous.
- sys_rst_req, in, 1: MCU SYSRESETREQ, level, synchronous.
- wdog_rst_req, in, 1: watchdog reset request, synchronous, 1-cycle pulse or level.
- dbg_rst_n, out, 1: active-low debug reset, drives the MCU nTRST.
- sys_rst_n, out, 1: active-low system reset, drives the MCU NRST.
- rst_done, out, 1: sequence complete.
- rst_cause, out, 2: last reset cause; 00 = POR, 01 = lock loss, 10 = sys request, 11 = watchdog.

Function
REQ-003 pll_locked SHALL pass through a 2-FF synchroniser; all decisions SHALL use the synchronised value lk.
REQ-004 The FSM SHALL have exactly these states: WAIT_LOCK, HOLD, REL_DBG, RUN.
REQ-005 All outputs SHALL be registered, and SHALL change in the same cycle the FSM enters the corresponding state.
REQ-006 WAIT_LOCK:
- The counter increments each cycle lk=1 and clears when lk=0.
- When lk=1 and counter=LOCK_CYC-1, the FSM SHALL go to HOLD.
- dbg_rst_n=0, sys_rst_n=0, rst_done=0.
REQ-007 HOLD:
- The counter clears on entry.
- At counter=HOLD_CYC-1, the FSM SHALL go to REL_DBG.
- sys_rst_n=0 and rst_done=0; dbg_rst_n keeps its value.
REQ-008 REL_DBG:
- dbg_rst_n=1 and the counter clears on entry.
- At counter=GAP_CYC-1, the FSM SHALL go to RUN.
REQ-009 RUN: sys_rst_n=1 and rst_done=1 on entry.
REQ-010 In RUN, lk=0 SHALL cause:
- transition to WAIT_LOCK;
- dbg_rst_n=0, sys_rst_n=0, rst_done=0;
- rst_cause=01.
REQ-011 In RUN, wdog_rst_req=1 SHALL cause:
- transition to HOLD;
- sys_rst_n=0, rst_done=0, rst_cause=11;
- dbg_rst_n stays 1.
REQ-012 In RUN, sys_rst_req=1 SHALL behave as REQ-011 but set rst_cause=10.
REQ-013 Same-cycle priority SHALL be lock loss > watchdog > sys request.
REQ-014 lk=0 in HOLD or REL_DBG SHALL abort to WAIT_LOCK with both resets asserted, rst_cause=01 and the counter cleared.
REQ-015 sys_rst_req and wdog_rst_req SHALL be ignored outside RUN; no request is queued.
REQ-016 A request level still high when RUN is re-entered SHALL re-trigger HOLD on the next cycle; no edge detection is performed.
REQ-017 rst_cause SHALL update only on the transitions in REQ-010 to REQ-014 and SHALL otherwise hold.
REQ-018 Counters SHALL saturate and never wrap; the counter SHALL clear on every state transition.

Reset
REQ-019 When fpga_rst_in=0, the block SHALL go immediately, with no clock needed, to:
- state WAIT_LOCK;
- dbg_rst_n=0, sys_rst_n=0, rst_done=0;
- rst_cause=00;
- counter 0 and synchroniser flops 0.
REQ-020 Reset release SHALL leave all outputs unchanged until the sequence of REQ-006 to REQ-009 runs.
REQ-021 Reset asserted mid-sequence, including in RUN, SHALL abort the sequence and set rst_cause=00.

Structure
REQ-022 A shared package fpga_rst_pkg SHALL hold:
- the state encodings;
- the rst_cause codes (RC_POR, RC_LOCK, RC_SYS, RC_WDOG).
REQ-023 The synchroniser SHALL be a separate sub-module fpga_sync2 (2-FF, async active-low clear), instantiated once.
REQ-024 The block SHALL be placed between fpga_clk_rst and cmsdk_mcu: sys_rst_n drives NRST and dbg_rst_n drives nTRST.

Verification
Parameters for all scenarios: LOCK_CYC=4, HOLD_CYC=8, GAP_CYC=2. Cycle 0 is the first cycle with lk=1.
REQ-025 Power-up with pll_locked=1:
- HOLD is entered at cycle 4.
- dbg_rst_n=1 at cycle 12.
- sys_rst_n=1 and rst_done=1 at cycle 14.
- rst_cause=00.
REQ-026 Lock glitch: lk=0 for 1 cycle at cycle 2 -> the counter restarts; HOLD is entered 4 cycles after lk returns high.
REQ-027 RUN with a 1-cycle wdog_rst_req:
- Next cycle: sys_rst_n=0, rst_cause=11, dbg_rst_n=1.
- sys_rst_n=1 again 10 cycles after HOLD entry.
REQ-028 RUN with sys_rst_req and wdog_rst_req both high in the same cycle -> rst_cause=11; with pll_locked also dropping at the same time -> rst_cause=01 and both resets low.
REQ-029 fpga_rst_in pulsed low for 1 ns while in RUN:
- All outputs go low asynchronously.
- rst_cause=00.
- The full sequence of REQ-025 repeats.
REQ-030 lk dropped during REL_DBG -> dbg_rst_n=0 on the next edge, WAIT_LOCK, rst_cause=01, sys_rst_n never rises.

Source files
------------

// File: rtl/fpga_rst_pkg.sv
// Shared encodings for the FPGA reset sequencer: FSM states and reset-cause codes.
package fpga_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        REL_DBG   = 2'd2,
        RUN       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RC_POR  = 2'b00,
        RC_LOCK = 2'b01,
        RC_SYS  = 2'b10,
        RC_WDOG = 2'b11
    } rst_cause_t;

endpackage

// File: rtl/fpga_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
module fpga_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/fpga_rst_seq.sv
// Reset sequencer between the clock/reset block and the MCU: waits for a stable
// PLL lock, holds reset, releases nTRST, then NRST; re-sequences on loss/requests.
//
// state     | meaning
// WAIT_LOCK | both resets asserted, counting consecutive lk-high cycles
// HOLD      | system reset held for HOLD_CYC cycles; debug reset unchanged
// REL_DBG   | debug reset released, GAP_CYC cycles before system release
// RUN       | sequence complete, watching lock loss and reset requests
module fpga_rst_seq
    import fpga_rst_pkg::*;
#(
    parameter int LOCK_CYC = 16,
    parameter int HOLD_CYC = 64,
    parameter int GAP_CYC  = 8,
    parameter int CNT_W    = 8
) (
    input  logic       fpga_clk_in,
    input  logic       fpga_rst_in,
    input  logic       pll_locked,
    input  logic       sys_rst_req,
    input  logic       wdog_rst_req,
    output logic       dbg_rst_n,
    output logic       sys_rst_n,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYC - 1);

    logic             w_lk;
    state_t           r_state, w_state_nxt;
    rst_cause_t       r_cause, w_cause_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dbg_rst_n, w_dbg_nxt;
    logic             r_sys_rst_n, w_sys_nxt;
    logic             r_done, w_done_nxt;

    fpga_sync2 u_sync_lock (
        .i_clk   (fpga_clk_in),
        .i_rst_n (fpga_rst_in),
        .i_d     (pll_locked),
        .o_q     (w_lk)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_dbg_nxt   = r_dbg_rst_n;
        w_sys_nxt   = r_sys_rst_n;
        w_done_nxt  = r_done;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            WAIT_LOCK: begin
                if (w_lk && r_cnt == LOCK_TC) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (!w_lk) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cause_nxt = RC_LOCK;
                end else if (r_cnt == HOLD_TC) begin
                    w_state_nxt = REL_DBG;
                end
            end
            REL_DBG: begin
                if (!w_lk) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cause_nxt = RC_LOCK;
                end else if (r_cnt == GAP_TC) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Lock loss wins over watchdog, which wins over the MCU request.
                if (!w_lk) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cause_nxt = RC_LOCK;
                end else if (wdog_rst_req) begin
                    w_state_nxt = HOLD;
                    w_cause_nxt = RC_WDOG;
                end else if (sys_rst_req) begin
                    w_state_nxt = HOLD;
                    w_cause_nxt = RC_SYS;
                end
            end
            default: w_state_nxt = WAIT_LOCK;
        endcase

        // Outputs are decoded from the next state so they switch on state entry.
        case (w_state_nxt)
            WAIT_LOCK: begin
                w_dbg_nxt  = 1'b0;
                w_sys_nxt  = 1'b0;
                w_done_nxt = 1'b0;
            end
            HOLD: begin
                w_sys_nxt  = 1'b0;
                w_done_nxt = 1'b0;
            end
            REL_DBG: begin
                w_dbg_nxt  = 1'b1;
                w_sys_nxt  = 1'b0;
                w_done_nxt = 1'b0;
            end
            RUN: begin
                w_dbg_nxt  = 1'b1;
                w_sys_nxt  = 1'b1;
                w_done_nxt = 1'b1;
            end
            default: ;
        endcase

        if (w_state_nxt != r_state)             w_cnt_nxt = '0;
        else if (r_state == WAIT_LOCK && !w_lk) w_cnt_nxt = '0;
        else if (r_cnt != '1)                   w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge fpga_clk_in or negedge fpga_rst_in) begin
        if (!fpga_rst_in) begin
            r_state     <= WAIT_LOCK;
            r_cause     <= RC_POR;
            r_cnt       <= '0;
            r_dbg_rst_n <= 1'b0;
            r_sys_rst_n <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cause     <= w_cause_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dbg_rst_n <= w_dbg_nxt;
            r_sys_rst_n <= w_sys_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign dbg_rst_n = r_dbg_rst_n;
    assign sys_rst_n = r_sys_rst_n;
    assign rst_done  = r_done;
    assign rst_cause = r_cause;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Scoreboard bench for fpga_rst_seq: a phase/time-left reference model predicts
// the outputs for every clock; a monitor compares them one cycle at a time.
module tb_fpga_rst_seq;

    localparam int LOCK  = 4;
    localparam int HOLDC = 8;
    localparam int GAP   = 2;

    localparam int PH_LOCK = 0;
    localparam int PH_HOLD = 1;
    localparam int PH_DBG  = 2;
    localparam int PH_RUN  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll = 1'b0;
    logic       sreq = 1'b0;
    logic       wreq = 1'b0;
    logic       dbg_rst_n, sys_rst_n, rst_done;
    logic [1:0] rst_cause;

    fpga_rst_seq #(
        .LOCK_CYC (LOCK),
        .HOLD_CYC (HOLDC),
        .GAP_CYC  (GAP),
        .CNT_W    (8)
    ) dut (
        .fpga_clk_in  (clk),
        .fpga_rst_in  (rst_n),
        .pll_locked   (pll),
        .sys_rst_req  (sreq),
        .wdog_rst_req (wreq),
        .dbg_rst_n    (dbg_rst_n),
        .sys_rst_n    (sys_rst_n),
        .rst_done     (rst_done),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    // {dbg_rst_n, sys_rst_n, rst_done, rst_cause}
    typedef logic [4:0] exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_phase;
    int   m_left;
    logic m_s1, m_s2;
    logic m_dbg, m_sys, m_done;
    logic [1:0] m_cause;

    task automatic model_reset();
        m_phase = PH_LOCK;
        m_left  = LOCK;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_dbg   = 1'b0;
        m_sys   = 1'b0;
        m_done  = 1'b0;
        m_cause = 2'b00;
    endtask

    task automatic model_abort();
        m_phase = PH_LOCK;
        m_left  = LOCK;
        m_dbg   = 1'b0;
        m_sys   = 1'b0;
        m_done  = 1'b0;
        m_cause = 2'b01;
    endtask

    // One clock edge of the intended behaviour; lk lags pll_locked by two edges.
    task automatic model_step(input logic p, input logic s, input logic w);
        logic lk;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = p;
        case (m_phase)
            PH_LOCK: begin
                if (lk) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_HOLD;
                        m_left  = HOLDC;
                    end
                end else begin
                    m_left = LOCK;
                end
            end
            PH_HOLD: begin
                if (!lk) model_abort();
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_DBG;
                        m_left  = GAP;
                        m_dbg   = 1'b1;
                    end
                end
            end
            PH_DBG: begin
                if (!lk) model_abort();
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_RUN;
                        m_sys   = 1'b1;
                        m_done  = 1'b1;
                    end
                end
            end
            default: begin
                if (!lk) model_abort();
                else if (w || s) begin
                    m_phase = PH_HOLD;
                    m_left  = HOLDC;
                    m_sys   = 1'b0;
                    m_done  = 1'b0;
                    m_cause = w ? 2'b11 : 2'b10;
                end
            end
        endcase
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if ({dbg_rst_n, sys_rst_n, rst_done, rst_cause} !== 5'b00000) begin
            n_fail++;
            $display("FAIL %s: got dbg=%b sys=%b done=%b cause=%b, want all 0",
                     name, dbg_rst_n, sys_rst_n, rst_done, rst_cause);
        end
    endtask

    task automatic cycle(input logic p, input logic s, input logic w, input bit pulse = 1'b0);
        @(negedge clk);
        if (pulse) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async_reset_pulse");
            rst_n = 1'b1;
            model_reset();
        end
        pll  = p;
        sreq = s;
        wreq = w;
        model_step(p, s, w);
        q.push_back({m_dbg, m_sys, m_done, m_cause});
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if ({dbg_rst_n, sys_rst_n, rst_done, rst_cause} !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs @%0t: got dbg/sys/done/cause=%b%b%b/%b, want %b%b%b/%b",
                         $time, dbg_rst_n, sys_rst_n, rst_done, rst_cause,
                         e[4], e[3], e[2], e[1:0]);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Power-up with lock already present, through to RUN.
        repeat (30) cycle(1'b1, 1'b0, 1'b0);

        // Watchdog pulse, then both requests together.
        cycle(1'b1, 1'b0, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);

        // Lock loss landing on lk in the same cycle as both requests.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        repeat (30) cycle(1'b1, 1'b0, 1'b0);

        // Held sys request re-triggers HOLD each time RUN is re-entered.
        repeat (40) cycle(1'b1, 1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);

        // Async reset while in RUN, then the full sequence again.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (25) cycle(1'b1, 1'b0, 1'b0);

        // Lock glitch during the lock count.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        repeat (25) cycle(1'b1, 1'b0, 1'b0);

        // Lock loss timed to land in REL_DBG.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 60 && !(m_phase == PH_HOLD && m_left == 2); i++)
            cycle(1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        repeat (25) cycle(1'b1, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic p, s, w;
            bit   pulse;
            p     = ($urandom_range(0, 59) != 0);
            s     = ($urandom_range(0, 24) == 0);
            w     = ($urandom_range(0, 29) == 0);
            pulse = ($urandom_range(0, 499) == 0);
            cycle(p, s, w, pulse);
        end

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
